// File: rtl/instr_memaccess.sv
// Memory-access pipeline stage of the pipelined MIPS core.
// Takes the execute-stage bundle, issues at most one word load/store per
// instruction over a req/ack data-memory port, and registers the MEM/WB
// bundle. Upstream is held via memStall while a request is outstanding,
// and a bubble (all-zero bundle) is emitted on every stall cycle.
module instr_memaccess (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [71:0] exbus,
  input  logic        exValid,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        memStall,
  output logic [70:0] membus,
  output logic [15:0] stallCount
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q;
  logic        dmem_req_q;
  logic        dmem_we_q;
  logic [31:0] dmem_addr_q;
  logic [31:0] dmem_wdata_q;
  logic [70:0] membus_q;
  logic [15:0] stall_count_q;
  logic [15:0] stall_count_d;

  // Execute-bundle fields
  logic [4:0]  ex_write_reg;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_write_data;
  logic        ex_memto_reg;
  logic        ex_reg_write;
  logic        ex_mem_write;
  logic        is_memop;
  logic        is_load;

  assign ex_write_reg  = exbus[4:0];
  assign ex_alu_out    = exbus[36:5];
  assign ex_write_data = exbus[68:37];
  assign ex_memto_reg  = exbus[69];
  assign ex_reg_write  = exbus[70];
  assign ex_mem_write  = exbus[71];

  // A set memWrite overrides memtoReg, so the illegal combination is a store.
  assign is_memop = exValid & (ex_memto_reg | ex_mem_write);
  assign is_load  = ex_memto_reg & ~ex_mem_write;

  // Stall while a memop is being accepted or while waiting for the ack.
  always_comb begin
    memStall = 1'b0;
    if (state_q == IDLE) begin
      memStall = is_memop;
    end else begin
      memStall = ~dmem_ack;
    end
  end

  // Saturating stall-cycle counter next value.
  always_comb begin
    stall_count_d = stall_count_q;
    if (memStall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  // Request/ack FSM with registered memory-port and MEM/WB outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'h0;
      dmem_wdata_q <= 32'h0;
      membus_q     <= 71'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_memop) begin
            dmem_req_q   <= 1'b1;
            dmem_we_q    <= ex_mem_write;
            dmem_addr_q  <= ex_alu_out;
            dmem_wdata_q <= ex_write_data;
            membus_q     <= 71'h0;
            state_q      <= BUSY;
          end else begin
            membus_q <= {ex_reg_write & exValid, ex_memto_reg & exValid,
                         32'h0, ex_alu_out, ex_write_reg};
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            // exbus is still held by upstream, so it describes this access.
            membus_q   <= {ex_reg_write, is_load,
                           is_load ? dmem_rdata : 32'h0,
                           ex_alu_out, ex_write_reg};
            dmem_req_q <= 1'b0;
            state_q    <= IDLE;
          end else begin
            membus_q <= 71'h0;
          end
        end
        default: begin
          state_q    <= IDLE;
          dmem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Performance counter; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= 16'h0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign membus     = membus_q;
  assign stallCount = stall_count_q;

endmodule

// File: tb/tb_instr_memaccess.sv
// Randomized self-checking bench for the memory-access stage. Each
// instruction is driven as upstream would (held while stalled), a memory
// responder acks after a chosen number of wait cycles, and every cycle's
// outputs are compared with values derived from the instruction fields.
module tb_instr_memaccess;

  logic        clk;
  logic        rst_n;
  logic [71:0] exbus;
  logic        exValid;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        memStall;
  logic [70:0] membus;
  logic [15:0] stallCount;

  int checks;
  int errors;
  int model_stalls;
  int txn_id;

  instr_memaccess dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .exbus      (exbus),
    .exValid    (exValid),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .memStall   (memStall),
    .membus     (membus),
    .stallCount (stallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drives one instruction through the stage and checks every cycle of it.
  task automatic run_instr(input logic mw, input logic rw, input logic mr,
                           input logic [31:0] wdata, input logic [31:0] alu,
                           input logic [4:0] wr, input logic valid,
                           input int waits, input logic [31:0] rdata,
                           input logic stray_ack);
    logic        memop;
    logic        load;
    logic [70:0] exp_mb;
    int          bubbles;
    bubbles = 0;
    memop   = valid & (mr | mw);
    load    = mr & ~mw;
    exbus      = {mw, rw, mr, wdata, alu, wr};
    exValid    = valid;
    dmem_ack   = stray_ack & ~memop;
    dmem_rdata = $urandom;
    if (!memop) begin
      exp_mb = {rw & valid, mr & valid, 32'h0, alu, wr};
      #1 check("stall_nonmem", memStall, 0);
      @(negedge clk);
      check("membus_nonmem", membus, exp_mb);
      check("req_nonmem", dmem_req, 0);
    end else begin
      exp_mb = {rw, load, load ? rdata : 32'h0, alu, wr};
      #1 check("stall_accept", memStall, 1);
      @(negedge clk);
      bubbles++;
      check("req_first", dmem_req, 1);
      check("we", dmem_we, mw);
      check("addr", dmem_addr, alu);
      check("wdata", dmem_wdata, wdata);
      check("bubble_first", membus, 0);
      for (int w = 0; w < waits; w++) begin
        check("stall_wait", memStall, 1);
        @(negedge clk);
        bubbles++;
        check("bubble_wait", membus, 0);
        check("req_hold", dmem_req, 1);
        check("addr_hold", dmem_addr, alu);
      end
      dmem_ack   = 1'b1;
      dmem_rdata = rdata;
      #1 check("stall_ack", memStall, 0);
      @(negedge clk);
      check("membus_mem", membus, exp_mb);
      check("req_drop", dmem_req, 0);
      dmem_ack = 1'b0;
      model_stalls = model_stalls + waits + 1;
      if (model_stalls > 65535) model_stalls = 65535;
    end
    check("stallcount", stallCount, model_stalls[15:0]);
    txn_id++;
    $display("txn %0d: valid=%0b mw=%0b mr=%0b rw=%0b alu=%h waits=%0d bubbles=%0d membus=%h stalls=%0d",
             txn_id, valid, mw, mr, rw, alu, memop ? waits : 0, bubbles, membus, stallCount);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    model_stalls = 0;
    txn_id       = 0;
    rst_n      = 1'b0;
    exbus      = 72'h0;
    exValid    = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    #1;
    check("rst_req", dmem_req, 0);
    check("rst_membus", membus, 0);
    check("rst_count", stallCount, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: ALU op, zero-wait load, 3-wait store, back-to-back load/store.
    run_instr(0, 1, 0, 32'h0, 32'h0000_1234, 5'd9, 1, 0, 32'h0, 0);
    run_instr(0, 1, 1, 32'h0, 32'h0000_0100, 5'd3, 1, 0, 32'hDEAD_BEEF, 0);
    run_instr(1, 0, 0, 32'h0000_55AA, 32'h0000_0200, 5'd0, 1, 3, 32'h1111_2222, 0);
    run_instr(0, 1, 1, 32'h0, 32'h0000_0300, 5'd7, 1, 1, 32'hCAFE_F00D, 0);
    check("gap_low", dmem_req, 0);
    run_instr(1, 0, 0, 32'hA5A5_0001, 32'h0000_0304, 5'd2, 1, 0, 32'h0, 0);
    // Illegal load+store acts as a store, bubble input passes nothing.
    run_instr(1, 1, 1, 32'h1234_5678, 32'h0000_0400, 5'd4, 1, 1, 32'hFFFF_FFFF, 0);
    run_instr(1, 1, 1, 32'h0, 32'h0000_0500, 5'd5, 0, 0, 32'h0, 1);

    // Randomized instruction stream with random waits and stray acks.
    for (int i = 0; i < 150; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      run_instr(kind[1], 1'($urandom), kind[0] | (kind == 3), $urandom, $urandom,
                5'($urandom), $urandom_range(0, 5) != 0, $urandom_range(0, 4),
                $urandom, 1'($urandom));
    end

    // Counter saturation, then confirm it stays saturated.
    run_instr(0, 1, 1, 32'h0, 32'h0000_0600, 5'd6, 1, 70000, 32'h0BAD_C0DE, 0);
    check("sat", stallCount, 16'hFFFF);
    run_instr(1, 0, 0, 32'h77, 32'h0000_0604, 5'd0, 1, 2, 32'h0, 0);
    check("sat_hold", stallCount, 16'hFFFF);

    // Asynchronous reset in the middle of a BUSY request.
    exbus   = {1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0700, 5'd8};
    exValid = 1'b1;
    @(negedge clk);
    check("busy_req", dmem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", dmem_req, 0);
    check("arst_membus", membus, 0);
    check("arst_count", stallCount, 0);
    check("arst_addr", dmem_addr, 0);
    exValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_stalls = 0;
    #1 check("post_rst_stall", memStall, 0);
    run_instr(0, 1, 0, 32'h0, 32'h0000_0ABC, 5'd11, 1, 0, 32'h0, 0);
    run_instr(0, 1, 1, 32'h0, 32'h0000_0800, 5'd12, 1, 0, 32'h1357_9BDF, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
